isp8_alu_seq: RTL

- Parametrised, registered successor to the 8-bit combinational datapath ALU of the isp8 core.
- Executes single-cycle ops (add/sub family, logic, 1-bit rotates) with latency 1.
- Adds iterative multi-cycle ops: unsigned shift-add multiply and barrel-free N-bit logical right shift.
- Sits between the register file and writeback; the core stalls on busy via a start/valid handshake.

---
 rtl/isp8_alu_pkg.sv | 34 +++
 rtl/isp8_alu_seq_if.sv | 30 +++
 rtl/isp8_alu_comb.sv | 52 +++++
 rtl/isp8_alu_seq.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/isp8_alu_pkg.sv
// Shared definitions for the registered isp8 ALU: opcodes, FSM encoding and
// the helper that decides whether an operation needs the iterative engine.
package isp8_alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_ADDC = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_SUBC = 4'd3;
    localparam logic [3:0] OP_CMP  = 4'd4;
    localparam logic [3:0] OP_MOV  = 4'd5;
    localparam logic [3:0] OP_AND  = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_XOR  = 4'd8;
    localparam logic [3:0] OP_TEST = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_ROL  = 4'd11;
    localparam logic [3:0] OP_RORC = 4'd12;
    localparam logic [3:0] OP_ROLC = 4'd13;
    localparam logic [3:0] OP_MUL  = 4'd14;
    localparam logic [3:0] OP_SHRN = 4'd15;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MUL_RUN = 2'd1,
        ST_SHR_RUN = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // A shift by zero has nothing to iterate, so it completes like a logic op.
    function automatic logic is_multicycle(input logic [3:0] op, input logic [7:0] shamt);
        return (op == OP_MUL) || ((op == OP_SHRN) && (shamt != 8'd0));
    endfunction

endpackage

// File: rtl/isp8_alu_seq_if.sv
// Core-to-ALU request/response bundle; the core drives master, the ALU is slave.
interface isp8_alu_seq_if #(
    parameter int DATA_WIDTH = 8
);
    // Handshake: an op is accepted on a rising edge where start_i && ready_o.
    // Operands are captured at that edge and ignored afterwards. valid_o is a
    // one-cycle pulse per accepted op; result/flag outputs hold until the next pulse.
    logic                  start_i;
    logic [3:0]            op_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic                  carry_i;
    logic                  ready_o;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] result_o;
    logic [DATA_WIDTH-1:0] result_hi_o;
    logic                  carry_o;
    logic                  zero_o;

    modport master (
        output start_i, op_i, a_i, b_i, carry_i,
        input  ready_o, valid_o, result_o, result_hi_o, carry_o, zero_o
    );

    modport slave (
        input  start_i, op_i, a_i, b_i, carry_i,
        output ready_o, valid_o, result_o, result_hi_o, carry_o, zero_o
    );

endinterface

// File: rtl/isp8_alu_comb.sv
// Combinational single-cycle datapath: add/sub family, logic ops and 1-bit rotates.
module isp8_alu_comb
    import isp8_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic [3:0]            op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic                  carry_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic                  carry_o
);
    localparam int W = DATA_WIDTH;

    logic [W:0] sum_w;
    logic [W:0] dif_w;

    always_comb begin
        // Bit W of the difference is the borrow: set whenever a - b (- c) < 0.
        sum_w    = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, (op_i == OP_ADDC) & carry_i};
        dif_w    = {1'b0, a_i} - {1'b0, b_i} - {{W{1'b0}}, (op_i == OP_SUBC) & carry_i};
        result_o = a_i;
        carry_o  = carry_i;
        case (op_i)
            OP_ADD, OP_ADDC: begin
                result_o = sum_w[W-1:0];
                carry_o  = sum_w[W];
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                result_o = dif_w[W-1:0];
                carry_o  = dif_w[W];
            end
            OP_MOV:          result_o = b_i;
            OP_AND, OP_TEST: result_o = a_i & b_i;
            OP_OR:           result_o = a_i | b_i;
            OP_XOR:          result_o = a_i ^ b_i;
            OP_ROR:          result_o = {b_i[0], b_i[W-1:1]};
            OP_ROL:          result_o = {b_i[W-2:0], b_i[W-1]};
            OP_RORC: begin
                result_o = {carry_i, b_i[W-1:1]};
                carry_o  = b_i[0];
            end
            OP_ROLC: begin
                result_o = {b_i[W-2:0], carry_i};
                carry_o  = b_i[W-1];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/isp8_alu_seq.sv
// Registered isp8 ALU: single-cycle ops complete in one cycle, MUL and SHRN
// iterate one step per clock under a small FSM.
module isp8_alu_seq
    import isp8_alu_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int SHAMT_W    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    isp8_alu_seq_if.slave     bus,
    output state_e            state_o
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     opa_q, opa_d;
    logic [W-1:0]     acc_hi_q, acc_hi_d;
    logic [W-1:0]     acc_lo_q, acc_lo_d;
    logic [W-1:0]     result_q, result_d;
    logic [W-1:0]     result_hi_q, result_hi_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;
    logic             valid_q, valid_d;

    logic             ready;
    logic             accept;
    logic             cnt_last;
    logic [CNT_W-1:0] shamt_cnt;
    logic [W-1:0]     comb_result;
    logic             comb_carry;
    logic [W:0]       mul_sum;
    logic [W-1:0]     mul_hi_nx;
    logic [W-1:0]     mul_lo_nx;
    logic [W-1:0]     shr_nx;

    isp8_alu_comb #(.DATA_WIDTH(W)) u_comb (
        .op_i     (bus.op_i),
        .a_i      (bus.a_i),
        .b_i      (bus.b_i),
        .carry_i  (bus.carry_i),
        .result_o (comb_result),
        .carry_o  (comb_carry)
    );

    assign ready     = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign accept    = bus.start_i && ready;
    assign cnt_last  = (cnt_q == CNT_W'(1));
    assign shamt_cnt = CNT_W'(bus.b_i[SHAMT_W-1:0]);

    // Shift-add multiply: {acc_hi, acc_lo} starts as {0, b}; each step adds a
    // into the high half when the multiplier LSB is set, then shifts right.
    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opa_q} : {(W+1){1'b0}});
    assign mul_hi_nx = mul_sum[W:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo_q[W-1:1]};
    assign shr_nx    = {1'b0, acc_lo_q[W-1:1]};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        valid_d     = 1'b0;
        case (state_q)
            ST_MUL_RUN: begin
                acc_hi_d = mul_hi_nx;
                acc_lo_d = mul_lo_nx;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    state_d     = ST_DONE;
                    valid_d     = 1'b1;
                    result_d    = mul_lo_nx;
                    result_hi_d = mul_hi_nx;
                    carry_d     = |mul_hi_nx;
                    zero_d      = ~|mul_lo_nx;
                end
            end
            ST_SHR_RUN: begin
                acc_lo_d = shr_nx;
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_last) begin
                    state_d     = ST_DONE;
                    valid_d     = 1'b1;
                    result_d    = shr_nx;
                    result_hi_d = '0;
                    carry_d     = acc_lo_q[0];
                    zero_d      = ~|shr_nx;
                end
            end
            default: begin
                // IDLE and DONE both accept; DONE falls back to IDLE otherwise.
                if (state_q == ST_DONE) state_d = ST_IDLE;
                if (accept) begin
                    if (is_multicycle(bus.op_i, 8'(bus.b_i[SHAMT_W-1:0]))) begin
                        opa_d    = bus.a_i;
                        acc_hi_d = '0;
                        if (bus.op_i == OP_MUL) begin
                            state_d  = ST_MUL_RUN;
                            cnt_d    = CNT_W'(W);
                            acc_lo_d = bus.b_i;
                        end else begin
                            state_d  = ST_SHR_RUN;
                            cnt_d    = shamt_cnt;
                            acc_lo_d = bus.a_i;
                        end
                    end else begin
                        valid_d     = 1'b1;
                        result_d    = comb_result;
                        result_hi_d = '0;
                        carry_d     = comb_carry;
                        zero_d      = ~|comb_result;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            carry_q     <= 1'b0;
            zero_q      <= 1'b0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            carry_q     <= carry_d;
            zero_q      <= zero_d;
            valid_q     <= valid_d;
        end
    end

    assign bus.ready_o     = ready;
    assign bus.valid_o     = valid_q;
    assign bus.result_o    = result_q;
    assign bus.result_hi_o = result_hi_q;
    assign bus.carry_o     = carry_q;
    assign bus.zero_o      = zero_q;
    assign state_o         = state_q;

endmodule
